// File: rtl/bus_node_p.sv
// Open-drain single-wire bus node: framed TX with CRC and bitwise arbitration/retry, filtered RX with CRC check.
// Latency: one bit per clock; tx_done/rx_valid pulse one clock after the stop bit is driven.
// Backpressure: tx_ready is low while a frame is pending or the node is busy; a lost frame retries itself.
module bus_node_p #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 64,
    parameter int                CRC_W     = 4,
    parameter logic [CRC_W-1:0]  CRC_POLY  = 'h3,
    parameter int                IDLE_BITS = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] my_addr,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [ADDR_W-1:0] tx_dest,
    input  logic [1:0]        tx_mode,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_done,
    output logic              tx_lost,
    output logic              rx_valid,
    output logic [ADDR_W-1:0] rx_src,
    output logic [1:0]        rx_mode,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_err,
    output logic              busy,
    inout  wire               bus
);

    localparam int HDR = 2*ADDR_W + 2 + DATA_W;
    localparam int L   = HDR + CRC_W + 2;
    localparam int IW  = $clog2(L);
    localparam int CW  = $clog2(IDLE_BITS + 1);
    localparam logic [IW-1:0]     LAST     = IW'(L - 1);
    localparam logic [IW-1:0]     HDR_LAST = IW'(HDR);
    localparam logic [CW-1:0]     IDLE_MAX = CW'(IDLE_BITS);
    localparam logic [ADDR_W-1:0] BCAST    = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_TX, ST_RX} state_t;

    state_t            state;
    logic              pending;
    logic [CW-1:0]     idle_cnt;
    logic [IW-1:0]     bit_idx;
    logic [CRC_W-1:0]  crc;
    logic [L-3:0]      rx_sh;
    logic [L-2:0]      tx_sh;
    logic              drv_low;
    logic [ADDR_W-1:0] p_dest;
    logic [1:0]        p_mode;
    logic [DATA_W-1:0] p_data;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        return {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ b) ? CRC_POLY : '0);
    endfunction

    function automatic logic [CRC_W-1:0] crc_calc(input logic [HDR-1:0] hdr);
        logic [CRC_W-1:0] c;
        logic [HDR-1:0]   b;
        c = '0;
        b = hdr;
        for (int i = 0; i < HDR; i++) begin
            c = crc_step(c, b[HDR-1]);
            b = b << 1;
        end
        return c;
    endfunction

    logic smp;
    assign smp = bus;
    assign bus = drv_low ? 1'b0 : 1'bz;

    // Everything after the start bit, MSB first, loaded when a transmission begins.
    logic [L-2:0] tx_body;
    assign tx_body = {p_dest, my_addr, p_mode, p_data,
                      crc_calc({p_dest, my_addr, p_mode, p_data}), 1'b1};

    // Received frame minus the start bit, valid on the stop-bit sample.
    logic [L-2:0]      frame;
    logic [ADDR_W-1:0] f_dest, f_src;
    logic [1:0]        f_mode;
    logic [DATA_W-1:0] f_data;
    logic [CRC_W-1:0]  f_crc;
    logic              f_stop, addressed, good, in_hdr, accept;
    logic [CRC_W-1:0]  crc_nxt;

    assign frame     = {rx_sh, smp};
    assign f_dest    = frame[L-2 -: ADDR_W];
    assign f_src     = frame[L-2-ADDR_W -: ADDR_W];
    assign f_mode    = frame[L-2-2*ADDR_W -: 2];
    assign f_data    = frame[L-4-2*ADDR_W -: DATA_W];
    assign f_crc     = frame[CRC_W:1];
    assign f_stop    = frame[0];
    assign addressed = ((f_dest == my_addr) || (f_dest == BCAST)) && (f_src != my_addr);
    assign good      = addressed && (f_crc == crc) && f_stop;
    assign in_hdr    = (bit_idx != '0) && (bit_idx <= HDR_LAST);
    assign crc_nxt   = in_hdr ? crc_step(crc, smp) : crc;
    assign accept    = tx_valid && tx_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            pending  <= 1'b0;
            idle_cnt <= '0;
            bit_idx  <= '0;
            crc      <= '0;
            rx_sh    <= '0;
            tx_sh    <= '0;
            drv_low  <= 1'b0;
            p_dest   <= '0;
            p_mode   <= '0;
            p_data   <= '0;
            tx_ready <= 1'b0;
            tx_done  <= 1'b0;
            tx_lost  <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_src   <= '0;
            rx_mode  <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_lost  <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (accept) begin
                pending <= 1'b1;
                p_dest  <= tx_dest;
                p_mode  <= tx_mode;
                p_data  <= tx_data;
            end
            case (state)
                ST_IDLE: begin
                    if (!smp) begin
                        // Someone else's start bit: it is already consumed.
                        state    <= ST_RX;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        idle_cnt <= '0;
                        bit_idx  <= IW'(1);
                        crc      <= '0;
                        rx_sh    <= {rx_sh[L-4:0], smp};
                    end else if (pending && idle_cnt == IDLE_MAX) begin
                        state    <= ST_TX;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        drv_low  <= 1'b1;
                        idle_cnt <= '0;
                        bit_idx  <= '0;
                        crc      <= '0;
                        tx_sh    <= tx_body;
                    end else begin
                        if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
                        tx_ready <= !(pending || accept);
                    end
                end
                ST_TX: begin
                    rx_sh <= {rx_sh[L-4:0], smp};
                    crc   <= crc_nxt;
                    if (bit_idx == LAST) begin
                        tx_done  <= 1'b1;
                        pending  <= 1'b0;
                        drv_low  <= 1'b0;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        idle_cnt <= '0;
                        tx_ready <= 1'b1;
                    end else if (!drv_low && !smp) begin
                        // Lost arbitration: keep listening from this very bit.
                        tx_lost <= 1'b1;
                        state   <= ST_RX;
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        drv_low <= ~tx_sh[L-2];
                        tx_sh   <= {tx_sh[L-3:0], 1'b1};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                ST_RX: begin
                    rx_sh   <= {rx_sh[L-4:0], smp};
                    crc     <= crc_nxt;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == LAST) begin
                        rx_valid <= good;
                        rx_err   <= addressed && !good;
                        if (good) begin
                            rx_src  <= f_src;
                            rx_mode <= f_mode;
                            rx_data <= f_data;
                        end
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        idle_cnt <= '0;
                        tx_ready <= !pending;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_node_p.sv
// Two-node bench (A=0, B=1) on a pulled-up bus with a raw open-drain injector.
module tb_bus_node_p;
    localparam int AW = 4, DW = 64, CW = 4;
    localparam int L  = 2*AW + DW + CW + 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a = 1'b0, rst_b = 1'b0;
    wire  bus;
    pullup (bus);
    logic tb_drv = 1'b0;
    assign bus = tb_drv ? 1'b0 : 1'bz;

    logic          a_tx_valid = 1'b0, b_tx_valid = 1'b0;
    logic [AW-1:0] a_tx_dest = '0, b_tx_dest = '0;
    logic [1:0]    a_tx_mode = '0, b_tx_mode = '0;
    logic [DW-1:0] a_tx_data = '0, b_tx_data = '0;
    logic          a_tx_ready, a_tx_done, a_tx_lost, a_rx_valid, a_rx_err, a_busy;
    logic          b_tx_ready, b_tx_done, b_tx_lost, b_rx_valid, b_rx_err, b_busy;
    logic [AW-1:0] a_rx_src, b_rx_src;
    logic [1:0]    a_rx_mode, b_rx_mode;
    logic [DW-1:0] a_rx_data, b_rx_data;

    bus_node_p u_a (
        .clock(clock), .reset_n(rst_a), .my_addr(4'd0),
        .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_dest(a_tx_dest),
        .tx_mode(a_tx_mode), .tx_data(a_tx_data), .tx_done(a_tx_done),
        .tx_lost(a_tx_lost), .rx_valid(a_rx_valid), .rx_src(a_rx_src),
        .rx_mode(a_rx_mode), .rx_data(a_rx_data), .rx_err(a_rx_err),
        .busy(a_busy), .bus(bus)
    );

    bus_node_p u_b (
        .clock(clock), .reset_n(rst_b), .my_addr(4'd1),
        .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_dest(b_tx_dest),
        .tx_mode(b_tx_mode), .tx_data(b_tx_data), .tx_done(b_tx_done),
        .tx_lost(b_tx_lost), .rx_valid(b_rx_valid), .rx_src(b_rx_src),
        .rx_mode(b_rx_mode), .rx_data(b_rx_data), .rx_err(b_rx_err),
        .busy(b_busy), .bus(bus)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pulse/occupancy monitor: counts and edge number of the latest pulse.
    int cyc = 0;
    int a_done_n, a_done_c, a_lost_n, a_lost_c, a_v_n, a_v_c, a_e_n, a_e_c, a_busy_n;
    int b_done_n, b_done_c, b_lost_n, b_lost_c, b_v_n, b_v_c, b_e_n, b_e_c, b_busy_n;

    task automatic clear_mon();
        a_done_n = 0; a_lost_n = 0; a_v_n = 0; a_e_n = 0; a_busy_n = 0;
        b_done_n = 0; b_lost_n = 0; b_v_n = 0; b_e_n = 0; b_busy_n = 0;
        a_done_c = -1; a_lost_c = -1; a_v_c = -1; a_e_c = -1;
        b_done_c = -1; b_lost_c = -1; b_v_c = -1; b_e_c = -1;
    endtask

    always @(posedge clock) begin
        cyc++;
        #1;
        if (a_tx_done)  begin a_done_n++; a_done_c = cyc; end
        if (a_tx_lost)  begin a_lost_n++; a_lost_c = cyc; end
        if (a_rx_valid) begin a_v_n++;    a_v_c    = cyc; end
        if (a_rx_err)   begin a_e_n++;    a_e_c    = cyc; end
        if (a_busy)     a_busy_n++;
        if (b_tx_done)  begin b_done_n++; b_done_c = cyc; end
        if (b_tx_lost)  begin b_lost_n++; b_lost_c = cyc; end
        if (b_rx_valid) begin b_v_n++;    b_v_c    = cyc; end
        if (b_rx_err)   begin b_e_n++;    b_e_c    = cyc; end
        if (b_busy)     b_busy_n++;
    end

    // Reference: CRC as the remainder of (header * x^CW) divided by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [73:0] hdr);
        bit         q[$];
        logic [4:0] g;
        g = 5'b10011;
        for (int i = 73; i >= 0; i--) q.push_back(hdr[i]);
        repeat (4) q.push_back(1'b0);
        for (int i = 0; i < 74; i++)
            if (q[i]) for (int j = 0; j < 5; j++) q[i+j] = q[i+j] ^ g[4-j];
        return {q[74], q[75], q[76], q[77]};
    endfunction

    function automatic bit is_for(input logic [3:0] dest, input logic [3:0] src, input logic [3:0] me);
        return ((dest == me) || (dest == 4'hF)) && (src != me);
    endfunction

    // kind: 0 = A transmits, 1 = B transmits, 2 = bench injects a raw frame.
    typedef struct {
        int          kind;
        logic [3:0]  dest;
        logic [3:0]  src;
        logic [1:0]  mode;
        logic [63:0] data;
        logic        crc_x;
        logic        stop;
        logic        av, ae, bv, be;
    } vec_t;

    logic [3:0]  m_src  [2] = '{4'd0, 4'd0};
    logic [1:0]  m_mode [2] = '{2'd0, 2'd0};
    logic [63:0] m_data [2] = '{64'd0, 64'd0};

    task automatic run_frame(input vec_t v, input string tag);
        int   pc;
        bit   fr[$];
        logic [73:0] hdr;
        logic [3:0]  c;
        repeat (8) @(posedge clock);
        @(negedge clock);
        clear_mon();
        if (v.kind == 0) begin
            check({tag, "_a_ready"}, 64'(a_tx_ready), 64'd1);
            a_tx_valid = 1'b1; a_tx_dest = v.dest; a_tx_mode = v.mode; a_tx_data = v.data;
            @(posedge clock); #1;
            pc = cyc + L + 1;
            @(negedge clock); a_tx_valid = 1'b0;
        end else if (v.kind == 1) begin
            check({tag, "_b_ready"}, 64'(b_tx_ready), 64'd1);
            b_tx_valid = 1'b1; b_tx_dest = v.dest; b_tx_mode = v.mode; b_tx_data = v.data;
            @(posedge clock); #1;
            pc = cyc + L + 1;
            @(negedge clock); b_tx_valid = 1'b0;
        end else begin
            hdr = {v.dest, v.src, v.mode, v.data};
            c = ref_crc(hdr) ^ {3'b000, v.crc_x};
            fr.push_back(1'b0);
            for (int i = 73; i >= 0; i--) fr.push_back(hdr[i]);
            for (int i = 3; i >= 0; i--) fr.push_back(c[i]);
            fr.push_back(v.stop);
            pc = cyc + L;
            foreach (fr[i]) begin
                tb_drv = !fr[i];
                @(negedge clock);
            end
            tb_drv = 1'b0;
        end
        repeat (L + 10) @(posedge clock);
        #2;
        if (v.kind == 0) begin
            check({tag, "_a_done_n"}, 64'(a_done_n), 64'd1);
            check({tag, "_a_done_cyc"}, 64'(a_done_c), 64'(pc));
            check({tag, "_a_busy_cycles"}, 64'(a_busy_n), 64'(L));
            check({tag, "_b_busy_cycles"}, 64'(b_busy_n), 64'(L - 1));
        end else if (v.kind == 1) begin
            check({tag, "_b_done_n"}, 64'(b_done_n), 64'd1);
            check({tag, "_b_done_cyc"}, 64'(b_done_c), 64'(pc));
            check({tag, "_b_busy_cycles"}, 64'(b_busy_n), 64'(L));
            check({tag, "_a_busy_cycles"}, 64'(a_busy_n), 64'(L - 1));
        end else begin
            check({tag, "_a_busy_cycles"}, 64'(a_busy_n), 64'(L - 1));
            check({tag, "_b_busy_cycles"}, 64'(b_busy_n), 64'(L - 1));
        end
        check({tag, "_a_rx_valid_n"}, 64'(a_v_n), 64'(v.av));
        check({tag, "_a_rx_err_n"},   64'(a_e_n), 64'(v.ae));
        check({tag, "_b_rx_valid_n"}, 64'(b_v_n), 64'(v.bv));
        check({tag, "_b_rx_err_n"},   64'(b_e_n), 64'(v.be));
        if (v.av) check({tag, "_a_rx_cyc"}, 64'(a_v_c), 64'(pc));
        if (v.bv) check({tag, "_b_rx_cyc"}, 64'(b_v_c), 64'(pc));
        if (v.ae) check({tag, "_a_err_cyc"}, 64'(a_e_c), 64'(pc));
        if (v.be) check({tag, "_b_err_cyc"}, 64'(b_e_c), 64'(pc));
        if (v.av) begin m_src[0] = v.src; m_mode[0] = v.mode; m_data[0] = v.data; end
        if (v.bv) begin m_src[1] = v.src; m_mode[1] = v.mode; m_data[1] = v.data; end
        check({tag, "_a_rx_src"},  64'(a_rx_src),  64'(m_src[0]));
        check({tag, "_a_rx_mode"}, 64'(a_rx_mode), 64'(m_mode[0]));
        check({tag, "_a_rx_data"}, a_rx_data, m_data[0]);
        check({tag, "_b_rx_src"},  64'(b_rx_src),  64'(m_src[1]));
        check({tag, "_b_rx_mode"}, 64'(b_rx_mode), 64'(m_mode[1]));
        check({tag, "_b_rx_data"}, b_rx_data, m_data[1]);
    endtask

    vec_t tbl[8];

    initial begin
        int acc;
        int r;
        vec_t v;
        logic [3:0] me;

        tbl[0] = '{0, 4'h1, 4'h0, 2'd1, 64'h1,                   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{0, 4'hF, 4'h0, 2'd2, 64'hDEADBEEF_00000001,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{0, 4'h2, 4'h0, 2'd0, 64'h0123456789ABCDEF,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{2, 4'h1, 4'h2, 2'd3, 64'hCAFE,                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{2, 4'hF, 4'h2, 2'd1, 64'h5555AAAA5555AAAA,    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{2, 4'h0, 4'h2, 2'd2, 64'h77,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1, 4'h0, 4'h1, 2'd3, 64'hA5A5A5A5_0F0F0F0F,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{2, 4'hF, 4'h1, 2'd0, 64'h1234,                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state.
        #2;
        check("rst_a_tx_ready", 64'(a_tx_ready), 64'd0);
        check("rst_b_tx_ready", 64'(b_tx_ready), 64'd0);
        check("rst_a_busy",     64'(a_busy),     64'd0);
        check("rst_b_rx_data",  b_rx_data,       64'd0);
        check("rst_bus_idle",   64'(bus),        64'd1);
        repeat (2) @(negedge clock);
        rst_a = 1'b1; rst_b = 1'b1;
        #1;
        check("rel_a_ready_before_edge", 64'(a_tx_ready), 64'd0);
        @(posedge clock); #1;
        check("rel_a_ready_after_edge", 64'(a_tx_ready), 64'd1);
        check("rel_b_ready_after_edge", 64'(b_tx_ready), 64'd1);

        for (int i = 0; i < 8; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

        // Arbitration: A(dest 1) loses to B(dest 0) on the last dest bit, then retries.
        repeat (8) @(posedge clock);
        @(negedge clock);
        clear_mon();
        a_tx_valid = 1'b1; a_tx_dest = 4'h1; a_tx_mode = 2'd2; a_tx_data = 64'h1111_2222_3333_4444;
        b_tx_valid = 1'b1; b_tx_dest = 4'h0; b_tx_mode = 2'd1; b_tx_data = 64'h9999_8888_7777_6666;
        @(posedge clock); #1;
        acc = cyc;
        @(negedge clock);
        a_tx_valid = 1'b0; b_tx_valid = 1'b0;
        for (int i = 0; i < 400 && a_done_n == 0; i++) @(posedge clock);
        #2;
        check("arb_a_lost_n",   64'(a_lost_n), 64'd1);
        check("arb_a_lost_cyc", 64'(a_lost_c), 64'(acc + 6));
        check("arb_b_lost_n",   64'(b_lost_n), 64'd0);
        check("arb_b_done_cyc", 64'(b_done_c), 64'(acc + L + 1));
        check("arb_a_rx_cyc",   64'(a_v_c),    64'(acc + L + 1));
        check("arb_a_done_n",   64'(a_done_n), 64'd1);
        check("arb_a_retry_cyc", 64'(a_done_c), 64'(acc + L + 1 + 5 + L));
        check("arb_b_rx_cyc",   64'(b_v_c),    64'(acc + L + 1 + 5 + L));
        check("arb_a_rx_n",     64'(a_v_n),    64'd1);
        check("arb_a_rx_src",   64'(a_rx_src), 64'd1);
        check("arb_a_rx_data",  a_rx_data,     64'h9999_8888_7777_6666);
        check("arb_b_rx_src",   64'(b_rx_src), 64'd0);
        check("arb_b_rx_mode",  64'(b_rx_mode), 64'd2);
        check("arb_b_rx_data",  b_rx_data,     64'h1111_2222_3333_4444);
        m_src[0] = 4'd1; m_mode[0] = 2'd1; m_data[0] = 64'h9999_8888_7777_6666;
        m_src[1] = 4'd0; m_mode[1] = 2'd2; m_data[1] = 64'h1111_2222_3333_4444;

        // Randomized frames against the reference rules.
        for (int k = 0; k < 10; k++) begin
            v.kind = int'($urandom_range(0, 2));
            r = int'($urandom_range(0, 3));
            v.dest = (r == 0) ? 4'h0 : (r == 1) ? 4'h1 : (r == 2) ? 4'hF : 4'($urandom_range(2, 14));
            v.mode = 2'($urandom_range(0, 3));
            v.data = {$urandom, $urandom};
            if (v.kind == 2) begin
                v.src   = 4'($urandom_range(0, 15));
                v.crc_x = ($urandom_range(0, 3) == 0);
                v.stop  = ($urandom_range(0, 3) != 0);
            end else begin
                v.src   = 4'(v.kind);
                v.crc_x = 1'b0;
                v.stop  = 1'b1;
            end
            me = 4'd0;
            v.av = is_for(v.dest, v.src, me) && !v.crc_x && v.stop;
            v.ae = is_for(v.dest, v.src, me) && !(!v.crc_x && v.stop);
            me = 4'd1;
            v.bv = is_for(v.dest, v.src, me) && !v.crc_x && v.stop;
            v.be = is_for(v.dest, v.src, me) && !(!v.crc_x && v.stop);
            run_frame(v, $sformatf("rnd%0d", k));
        end

        // Reset of A in the middle of its data field.
        repeat (8) @(posedge clock);
        @(negedge clock);
        clear_mon();
        a_tx_valid = 1'b1; a_tx_dest = 4'h2; a_tx_mode = 2'd0; a_tx_data = 64'h0;
        @(posedge clock); #1;
        @(negedge clock);
        a_tx_valid = 1'b0;
        repeat (31) @(posedge clock);
        @(negedge clock);
        check("mid_bus_low_before", 64'(bus), 64'd0);
        rst_a = 1'b0;
        #1;
        check("mid_bus_released", 64'(bus), 64'd1);
        check("mid_a_busy", 64'(a_busy), 64'd0);
        check("mid_a_rx_data_cleared", a_rx_data, 64'd0);
        m_src[0] = 4'd0; m_mode[0] = 2'd0; m_data[0] = 64'd0;
        repeat (3) @(negedge clock);
        rst_a = 1'b1;
        #1;
        check("mid_a_ready_before_edge", 64'(a_tx_ready), 64'd0);
        @(posedge clock); #1;
        check("mid_a_ready_after_edge", 64'(a_tx_ready), 64'd1);
        repeat (150) @(posedge clock);
        #2;
        check("mid_a_done_n", 64'(a_done_n), 64'd0);
        check("mid_a_busy_after", 64'(a_busy), 64'd0);
        check("mid_b_rx_valid_n", 64'(b_v_n), 64'd0);
        check("mid_b_rx_err_n", 64'(b_e_n), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_node_p.md
Name: bus_node_p

Overview:
- Parametrised second-generation node for the shared single-wire serial bus.
- Each node frames a (dest, src, mode, data) word with a CRC and transmits it one bit per clock over an open-drain wired-AND line.
- Adds over the first-generation node: bitwise arbitration with automatic retry, an idle-gap rule, a receive path with address and broadcast filtering, and CRC checking.
- Several instances share one `bus` net that carries a pull-up.

Parameters:
- ADDR_W, 4, node/destination address width; all-ones is the broadcast address.
- DATA_W, 64, payload width.
- CRC_W, 4, CRC width.
- CRC_POLY, 4'h3, CRC polynomial without the implicit top term (default x^4+x+1).
- IDLE_BITS, 4, consecutive idle (1) bus samples required before a node may start a frame.

Ports:
- clock, input, 1, single clock; all state updates on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- my_addr, input, ADDR_W, this node's address; static during operation.
- tx_valid, input, 1, transmit request.
- tx_ready, output, 1, node can accept a frame.
- tx_dest, input, ADDR_W, destination address.
- tx_mode, input, 2, mode field carried opaquely.
- tx_data, input, DATA_W, payload.
- tx_done, output, 1, one-cycle pulse: frame sent and won arbitration.
- tx_lost, output, 1, one-cycle pulse: arbitration lost; frame kept for retry.
- rx_valid, output, 1, one-cycle pulse: good frame for this node.
- rx_src, output, ADDR_W, source of last good frame.
- rx_mode, output, 2, mode of last good frame.
- rx_data, output, DATA_W, payload of last good frame.
- rx_err, output, 1, one-cycle pulse: addressed frame with CRC or stop-bit error.
- busy, output, 1, node in TX or RX.
- bus, inout, 1, open-drain line: node drives 0 or Z, never 1.

Behaviour:
- Reset (async, immediate):
  - Bus released (Z).
  - FSM=IDLE, pending=0, idle_cnt=0.
  - All outputs 0, including tx_ready and rx_src/rx_mode/rx_data.
  - tx_ready rises on the first clock edge after reset_n deasserts.
  - Reset mid-frame aborts the frame: no tx_done, pending frame discarded.
- Frame, MSB first per field: start(0), dest[ADDR_W], src[ADDR_W] (=my_addr), mode[2], data[DATA_W], crc[CRC_W], stop(1).
  - Length L = 2*ADDR_W + DATA_W + CRC_W + 4; 80 with defaults.
- CRC:
  - Register initialised to 0 at the start bit.
  - For each bit b from dest through data: fb = crc[CRC_W-1]^b; crc = (crc<<1) ^ (fb ? CRC_POLY : 0).
  - Transmitted MSB first; receiver recomputes and compares.
- Timing:
  - Drive-low flop is registered.
  - Bus is sampled at the next rising edge.
  - One bit per clock.
- Handshake:
  - tx_ready is registered; it is 1 iff FSM=IDLE and pending=0.
  - A frame is accepted when tx_valid && tx_ready on a clock edge. The fields are latched and pending is set, and tx_ready falls on that same edge.
- IDLE:
  - idle_cnt counts consecutive 1 samples and saturates at IDLE_BITS.
  - A 0 sample resets idle_cnt.
  - If a 0 sample occurs and the node is not driving, it is a foreign start bit: go to RX with the start bit consumed.
  - If pending and idle_cnt==IDLE_BITS: drive the start bit and go to TX.
  - A foreign start and a local start in the same cycle are indistinguishable. Both nodes are in TX; this is resolved by arbitration.
- TX:
  - Each bit: drive 0 for a 0 bit, Z for a 1 bit; sample the bus.
  - Sent 1 but sampled 0: tx_lost pulse, release the bus, go to RX at the same bit index with 0 as the received bit. The running CRC and shift state carry over. pending stays 1.
  - Lowest (dest, src) wins; unique addresses guarantee a single winner.
  - At stop-bit sample: tx_done pulse, pending=0, go to IDLE with idle_cnt=0.
  - A node never delivers its own frame to rx_*.
- RX:
  - Shift in L bits.
  - Frame is addressed when dest==my_addr or dest=all-ones, and src!=my_addr.
  - Addressed and CRC ok and stop==1: rx_valid pulse. rx_src/rx_mode/rx_data update on the same edge and hold until the next rx_valid.
  - Addressed and (CRC bad or stop==0): rx_err pulse; rx_* unchanged.
  - Not addressed: no pulse.
  - Then IDLE with idle_cnt=0.
- The retry after a loss happens automatically once IDLE_BITS idle samples have been seen.
- busy=1 in TX/RX, 0 otherwise.
- The sender's tx_done and the receivers' rx_valid pulse on the same edge, one clock after the stop bit is driven.

Test Plan:
- Bench setup: nodes A (my_addr=0) and B (my_addr=1) on a pulled-up bus, default parameters.
- Unicast: A sends tx_dest=1, tx_mode=1, tx_data=64'h1 → after IDLE_BITS idle, 80 bit-clocks later:
  - A: tx_done.
  - B, same edge: rx_valid with rx_src=0, rx_mode=1, rx_data=64'h1.
  - A: rx_valid stays 0.
- Arbitration: A (dest=1) and B (dest=0) accepted on the same edge →
  - A: tx_lost on the 4th dest bit.
  - A: rx_valid with rx_src=1.
  - B: tx_done.
  - Then A retries after a 4-cycle gap; B rx_valid with rx_src=0.
- Broadcast: A sends dest=4'hF, data=64'hDEADBEEF_00000001 → B rx_valid with that data; A rx_valid=0.
- CRC error: bench open-drain driver injects a raw frame with dest=1, src=2, crc field XOR 1 → B rx_err pulse, no rx_valid, rx_data unchanged.
- Filter: A sends dest=2 → B: no rx_valid, no rx_err; B busy=1 for the frame.
- Reset mid-frame: pull reset_n low at A's data bit 20 →
  - A: bus Z in the same timestep.
  - A: tx_done never pulses.
  - A: tx_ready=1 one clock after reset_n rises.
